// File: rtl/press_conditioner.sv
// press_conditioner: synchronise, debounce and pulse-encode a bouncy push-button level
module press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic release_pulse,
  output logic level,
  output logic long_press
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] L_MAX = HW'(LONG_CYCLES);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q;
  logic [DW-1:0] dcnt_q, dcnt_d, dinc;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic press_q, press_d, rel_q, rel_d, level_q, level_d, long_q, long_d;
  // Next-state: dcnt is zero on entry to IDLE and HELD, so dinc is the run length of the new level
  always_comb begin
    dinc    = dcnt_q + DW'(1);
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    if (state_q == IDLE || state_q == PRESS_WAIT) begin
      if (!s2_q) begin
        state_d = IDLE;
        dcnt_d  = '0;
      end else if (dinc == D_MAX) begin
        state_d = HELD;
        dcnt_d  = '0;
        hcnt_d  = '0;
        press_d = 1'b1;
      end else begin
        state_d = PRESS_WAIT;
        dcnt_d  = dinc;
      end
    end else begin
      if (state_q == HELD) hcnt_d = (hcnt_q == L_MAX) ? hcnt_q : hcnt_q + HW'(1);
      if (s2_q) begin
        state_d = HELD;
        dcnt_d  = '0;
      end else if (dinc == D_MAX) begin
        state_d = IDLE;
        dcnt_d  = '0;
        hcnt_d  = '0;
        rel_d   = 1'b1;
      end else begin
        state_d = RELEASE_WAIT;
        dcnt_d  = dinc;
      end
      long_d = (state_q == HELD) && (hcnt_q == L_MAX - HW'(1)) && !rel_d;
    end
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end
  // Synchroniser, FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      level_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      level_q <= level_d;
      long_q  <= long_d;
    end
  end
  assign press         = press_q;
  assign release_pulse = rel_q;
  assign level         = level_q;
  assign long_press    = long_q;
endmodule

// File: tb/tb_press_conditioner.sv
// tb_press_conditioner: scoreboard bench for press_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=16
module tb_press_conditioner;
  logic clk = 1'b0, rst = 1'b0, btn = 1'b0;
  logic press, release_pulse, level, long_press;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {logic [2:0] kind; int cyc; logic lvl;} exp_t;
  exp_t q[$];
  localparam logic [2:0] K_PRESS = 3'b001, K_REL = 3'b010, K_LONG = 3'b100;

  press_conditioner #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .btn(btn), .press(press),
    .release_pulse(release_pulse), .level(level), .long_press(long_press)
  );

  always #2 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic push(logic [2:0] k, int c, logic l);
    q.push_back('{kind: k, cyc: c, lvl: l});
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int outs();
    return int'({press, release_pulse, level, long_press});
  endfunction

  // Monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (press || release_pulse || long_press) begin
      if (q.size() == 0) check("unexpected_pulse", int'({long_press, release_pulse, press}), 0);
      else begin
        e = q.pop_front();
        check("pulse_kind", int'({long_press, release_pulse, press}), int'(e.kind));
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_level", int'(level), int'(e.lvl));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b0;
    btn = 1'b1;
    step(1);
    check("reset_outs_a", outs(), 0);
    step(1);
    check("reset_outs_b", outs(), 0);
    rst = 1'b1;
    push(K_PRESS, cyc + 6, 1'b1);
    step(8);
    check("level_after_reset_press", int'(level), 1);
    btn = 1'b0;
    push(K_REL, cyc + 6, 1'b0);
    step(10);
    check("level_after_release", int'(level), 0);
    // clean 10-cycle press
    btn = 1'b1;
    push(K_PRESS, cyc + 6, 1'b1);
    step(10);
    btn = 1'b0;
    push(K_REL, cyc + 6, 1'b0);
    step(10);
    // bounce: toggle each cycle, then settle high
    for (int i = 0; i < 5; i++) begin
      btn = ~i[0];
      if (i == 4) push(K_PRESS, cyc + 6, 1'b1);
      step(1);
    end
    step(9);
    btn = 1'b0;
    push(K_REL, cyc + 6, 1'b0);
    step(10);
    // 3-cycle glitch from idle
    btn = 1'b1;
    step(3);
    btn = 1'b0;
    step(2);
    check("glitch_level_a", int'(level), 0);
    step(8);
    check("glitch_level_b", int'(level), 0);
    // long press held 25 cycles
    btn = 1'b1;
    push(K_PRESS, cyc + 6, 1'b1);
    push(K_LONG, cyc + 22, 1'b1);
    step(25);
    btn = 1'b0;
    push(K_REL, cyc + 6, 1'b0);
    step(30);
    // release bounce while held: two low samples freeze the hold count for two cycles
    n = cyc;
    btn = 1'b1;
    push(K_PRESS, n + 6, 1'b1);
    push(K_LONG, n + 24, 1'b1);
    step(9);
    btn = 1'b0;
    step(2);
    btn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("bounce_level_held", int'(level), 1);
    end
    step(13);
    btn = 1'b0;
    push(K_REL, cyc + 6, 1'b0);
    step(12);
    // reset during PRESS_WAIT, then restart with button still high
    btn = 1'b1;
    step(4);
    #1 rst = 1'b0;
    #1 check("rst_in_press_wait", outs(), 0);
    step(2);
    rst = 1'b1;
    push(K_PRESS, cyc + 6, 1'b1);
    step(9);
    check("level_before_rst_held", int'(level), 1);
    #1 rst = 1'b0;
    #1 check("rst_in_held", outs(), 0);
    btn = 1'b0;
    step(2);
    rst = 1'b1;
    step(12);
    check("level_after_rst_held", int'(level), 0);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
